urv_writeback: RTL and testbench
================================

# urv_writeback

Writeback stage of the uRV pipeline: the producer side of the register file write port and its bypass path. It accepts one retiring result per cycle from the execute stage. For loads, it waits for the data-memory response, then sign- or zero-extends and aligns the returned word. It then drives the register-file write and bypass signals. It stalls upstream while a load is outstanding and flags loads that never complete.

## Interface
Parameters:
- g_load_timeout, 255, cycles to wait for dm_load_done_i before a load is abandoned (1..255; 8-bit counter)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- x_valid_i  in  1  execute stage presents a retiring instruction
- x_rd_i  in  5  destination register index
- x_rd_value_i  in  32  ALU/CSR result (non-load)
- x_rd_write_i  in  1  instruction writes rd
- x_load_i  in  1  instruction is a load
- x_fun_i  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- x_dm_addr_lsb_i  in  2  low bits of load address
- dm_load_done_i  in  1  load data valid (single-cycle pulse)
- dm_data_l_i  in  32  raw load word
- w_stall_o  out  1  writeback busy; upstream must hold x_* stable
- w_rd_o  out  5  register file write index
- w_rd_value_o  out  32  register file write data
- w_rd_store_o  out  1  register file write enable
- w_bypass_rd_write_o  out  1  bypass valid
- w_bypass_rd_value_o  out  32  bypass data
- w_load_fault_o  out  1  one-cycle pulse: load timed out

## Operation
- FSM states: IDLE, LOAD_WAIT. Reset state: IDLE.
- Reset values: w_rd_o=0, w_rd_value_o=0, w_rd_store_o=0, w_bypass_rd_write_o=0, w_bypass_rd_value_o=0, w_load_fault_o=0, w_stall_o=0, timeout counter=0.
- Accept condition: x_valid_i && !w_stall_o.
  - x_rd_i and x_fun_i/lsb are registered on every accept.
- Non-load accept with x_rd_write_i=1:
  - Next cycle w_rd_store_o=1 and w_bypass_rd_write_o=1.
  - w_rd_value_o = w_bypass_rd_value_o = x_rd_value_i.
- Non-load with x_rd_write_i=0: no store next cycle.
- Load accept with x_rd_write_i=1: go to LOAD_WAIT and clear the counter. Without x_rd_write_i, the load is a no-op (no wait).
- rd==0: store and bypass are suppressed in all cases. A load to x0 still waits for dm_load_done_i.
- In LOAD_WAIT, w_stall_o=1 (combinational from state). The counter increments each cycle without done.
- On dm_load_done_i in LOAD_WAIT:
  - Align the data:
    - Byte = dm_data_l_i[8*lsb+7 : 8*lsb].
    - Half = lsb[1] ? [31:16] : [15:0].
    - LW uses the full word.
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - Next cycle w_rd_store_o=1 with the aligned value; w_bypass_rd_write_o stays 0 (load data never bypassed).
  - Return to IDLE.
- Timeout: if the counter reaches g_load_timeout without done:
  - Pulse w_load_fault_o for 1 cycle.
  - No store.
  - Return to IDLE.
- dm_load_done_i in IDLE is ignored.
- Undefined funct3 (011, 11x): treated as LW.
- Store and bypass outputs are single-cycle; they deassert unless a new write is produced.

## Timing
- Non-load: accept at cycle N → w_rd_store_o high in N+1 only. Back-to-back accepts give back-to-back stores.
- Load: accept at N → w_stall_o high from N+1.
  - dm_load_done_i sampled at M (M ≥ N+1) → store in M+1.
  - w_stall_o low in M+1, so a new accept is possible at M+1.
  - Minimum load latency: 2 cycles.
- Timeout: done absent for g_load_timeout LOAD_WAIT cycles → fault pulse and stall release in the following cycle.
- Done arriving on the same cycle the counter hits the limit: done wins; store, no fault.
- Asynchronous reset mid-load: immediately to IDLE, all outputs cleared, pending load discarded.

## Test plan
- ALU writes: x1←0x11111111, x2←0x22222222 on consecutive cycles.
  → w_rd_store_o high two consecutive cycles, rd 1 then 2, bypass mirrors both.
- LB from lsb=3, data 0x80FF_FF00; LBU same.
  → 0xFFFFFF80; LBU → 0x00000080; no bypass; store 1 cycle after done.
- LH lsb=2, data 0x8001_1234 → 0xFFFF8001. LHU lsb=0 → 0x00001234. LW → 0x80011234.
- Load to x5, done delayed 10 cycles, x_valid_i held high.
  → w_stall_o high 10 cycles, no accept until the cycle after store.
- g_load_timeout=4, no done.
  → w_load_fault_o pulse on the 5th cycle after accept, no store, stall drops; done arriving later is ignored.
- Write to x0 (ALU and load).
  → w_rd_store_o and bypass never asserted.
- Reset asserted during LOAD_WAIT.
  → outputs zero, stall zero.

Source files
------------

// File: rtl/urv_writeback.sv
// uRV writeback stage: drives the register file write port and bypass path,
// waits for data-memory load responses and aligns/extends the returned word.
module urv_writeback #(
    parameter int g_load_timeout = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_rd_write_i,
    input  logic        x_load_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_lsb_i,
    input  logic        dm_load_done_i,
    input  logic [31:0] dm_data_l_i,
    output logic        w_stall_o,
    output logic [4:0]  w_rd_o,
    output logic [31:0] w_rd_value_o,
    output logic        w_rd_store_o,
    output logic        w_bypass_rd_write_o,
    output logic [31:0] w_bypass_rd_value_o,
    output logic        w_load_fault_o
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    // The last LOAD_WAIT cycle is the one where the counter equals limit-1.
    localparam logic [7:0] LIMIT = 8'(g_load_timeout - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  fun;
    logic [1:0]  lsb;

    function automatic logic [31:0] align_load(input logic [2:0]  f,
                                               input logic [1:0]  a,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[8*a +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (f)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign w_stall_o = (state == LOAD_WAIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state               <= IDLE;
            cnt                 <= 8'd0;
            fun                 <= 3'd0;
            lsb                 <= 2'd0;
            w_rd_o              <= 5'd0;
            w_rd_value_o        <= 32'd0;
            w_rd_store_o        <= 1'b0;
            w_bypass_rd_write_o <= 1'b0;
            w_bypass_rd_value_o <= 32'd0;
            w_load_fault_o      <= 1'b0;
        end else begin
            w_rd_store_o        <= 1'b0;
            w_bypass_rd_write_o <= 1'b0;
            w_load_fault_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (x_valid_i) begin
                        w_rd_o <= x_rd_i;
                        fun    <= x_fun_i;
                        lsb    <= x_dm_addr_lsb_i;
                        if (x_load_i) begin
                            if (x_rd_write_i) begin
                                state <= LOAD_WAIT;
                                cnt   <= 8'd0;
                            end
                        end else if (x_rd_write_i) begin
                            w_rd_store_o        <= (x_rd_i != 5'd0);
                            w_bypass_rd_write_o <= (x_rd_i != 5'd0);
                            w_rd_value_o        <= x_rd_value_i;
                            w_bypass_rd_value_o <= x_rd_value_i;
                        end
                    end
                end
                LOAD_WAIT: begin
                    // A done on the limit cycle still completes the load.
                    if (dm_load_done_i) begin
                        w_rd_store_o <= (w_rd_o != 5'd0);
                        w_rd_value_o <= align_load(fun, lsb, dm_data_l_i);
                        state        <= IDLE;
                    end else if (cnt == LIMIT) begin
                        w_load_fault_o <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_urv_writeback.sv
// Bench for urv_writeback: directed scenarios plus randomized ALU/load traffic
// compared against a transaction-level model of the writeback rules.
module tb_urv_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        x_valid = 0, x_rd_write = 0, x_load = 0, done = 0;
    logic [4:0]  x_rd = 0;
    logic [31:0] x_val = 0, data = 0;
    logic [2:0]  x_fun = 0;
    logic [1:0]  x_lsb = 0;

    logic        stall, store, byp, fault;
    logic [4:0]  rd;
    logic [31:0] val, byp_val;
    logic        t_stall, t_store, t_byp, t_fault;
    logic [4:0]  t_rd;
    logic [31:0] t_val, t_byp_val;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    urv_writeback dut (
        .clk_i(clk), .rst_i(rst), .x_valid_i(x_valid), .x_rd_i(x_rd),
        .x_rd_value_i(x_val), .x_rd_write_i(x_rd_write), .x_load_i(x_load),
        .x_fun_i(x_fun), .x_dm_addr_lsb_i(x_lsb), .dm_load_done_i(done),
        .dm_data_l_i(data), .w_stall_o(stall), .w_rd_o(rd), .w_rd_value_o(val),
        .w_rd_store_o(store), .w_bypass_rd_write_o(byp),
        .w_bypass_rd_value_o(byp_val), .w_load_fault_o(fault)
    );

    urv_writeback #(.g_load_timeout(4)) dut_t (
        .clk_i(clk), .rst_i(rst), .x_valid_i(x_valid), .x_rd_i(x_rd),
        .x_rd_value_i(x_val), .x_rd_write_i(x_rd_write), .x_load_i(x_load),
        .x_fun_i(x_fun), .x_dm_addr_lsb_i(x_lsb), .dm_load_done_i(done),
        .dm_data_l_i(data), .w_stall_o(t_stall), .w_rd_o(t_rd), .w_rd_value_o(t_val),
        .w_rd_store_o(t_store), .w_bypass_rd_write_o(t_byp),
        .w_bypass_rd_value_o(t_byp_val), .w_load_fault_o(t_fault)
    );

    // Reference extraction: shift the word down, mask, then extend by value range.
    function automatic logic [31:0] ref_load(input int f, input int a, input logic [31:0] w);
        logic [31:0] v;
        case (f)
            0, 4: begin
                v = (w >> (8 * a)) & 32'h0000_00FF;
                if (f == 0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            1, 5: begin
                v = (a >= 2) ? (w >> 16) : (w & 32'h0000_FFFF);
                if (f == 1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        x_valid = 0; x_rd_write = 0; x_load = 0; done = 0;
        x_rd = 0; x_val = 0; x_fun = 0; x_lsb = 0; data = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 0;
        cycle();
        rst = 1;
        cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #3;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall); end
        n_cmp++; if (rd !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %0d want 0", rd); end
        n_cmp++; if (val !== 32'd0) begin n_bad++; $display("FAIL reset_val got %h want 0", val); end
        n_cmp++; if (store !== 1'b0) begin n_bad++; $display("FAIL reset_store got %0b want 0", store); end
        n_cmp++; if (byp !== 1'b0) begin n_bad++; $display("FAIL reset_byp got %0b want 0", byp); end
        n_cmp++; if (byp_val !== 32'd0) begin n_bad++; $display("FAIL reset_bypval got %h want 0", byp_val); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %0b want 0", fault); end
        cycle();
        rst = 1;
        cycle();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        x_valid = 1; x_rd_write = 1; x_load = 0; x_rd = 1; x_val = 32'h1111_1111;
        cycle();
        x_rd = 2; x_val = 32'h2222_2222;
        n_cmp++; if ({store, byp, rd, val, byp_val} !== {1'b1, 1'b1, 5'd1, 32'h1111_1111, 32'h1111_1111}) begin
            n_bad++; $display("FAIL alu_x1 got st=%0b by=%0b rd=%0d v=%h bv=%h want 1 1 1 11111111", store, byp, rd, val, byp_val); end
        cycle();
        x_valid = 0;
        n_cmp++; if ({store, byp, rd, val, byp_val} !== {1'b1, 1'b1, 5'd2, 32'h2222_2222, 32'h2222_2222}) begin
            n_bad++; $display("FAIL alu_x2 got st=%0b by=%0b rd=%0d v=%h bv=%h want 1 1 2 22222222", store, byp, rd, val, byp_val); end
        cycle();
        n_cmp++; if ({store, byp} !== 2'b00) begin n_bad++; $display("FAIL alu_after got st=%0b by=%0b want 0 0", store, byp); end
        x_valid = 1; x_rd = 3; x_rd_write = 0;
        cycle();
        x_valid = 0;
        n_cmp++; if (store !== 1'b0) begin n_bad++; $display("FAIL alu_nowrite got st=%0b want 0", store); end
    endtask

    typedef struct { logic [2:0] f; logic [1:0] a; logic [31:0] d; logic [31:0] exp; } lcase_t;

    task automatic test_load_align();
        lcase_t tbl[8];
        tbl[0] = '{3'b000, 2'd3, 32'h80FF_FF00, 32'hFFFF_FF80};
        tbl[1] = '{3'b100, 2'd3, 32'h80FF_FF00, 32'h0000_0080};
        tbl[2] = '{3'b001, 2'd2, 32'h8001_1234, 32'hFFFF_8001};
        tbl[3] = '{3'b101, 2'd0, 32'h8001_1234, 32'h0000_1234};
        tbl[4] = '{3'b010, 2'd0, 32'h8001_1234, 32'h8001_1234};
        tbl[5] = '{3'b011, 2'd1, 32'hCAFE_BABE, 32'hCAFE_BABE};
        tbl[6] = '{3'b110, 2'd2, 32'h1234_5678, 32'h1234_5678};
        tbl[7] = '{3'b000, 2'd1, 32'h0000_7F00, 32'h0000_007F};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            x_valid = 1; x_load = 1; x_rd_write = 1; x_rd = 5'(i + 8);
            x_fun = tbl[i].f; x_lsb = tbl[i].a; x_val = 32'hDEAD_0000;
            cycle();
            x_valid = 0; x_load = 0;
            n_cmp++; if ({stall, store} !== 2'b10) begin n_bad++; $display("FAIL ld%0d_wait got stall=%0b st=%0b want 1 0", i, stall, store); end
            done = 1; data = tbl[i].d;
            cycle();
            done = 0;
            n_cmp++; if ({store, byp, stall, rd, val} !== {1'b1, 1'b0, 1'b0, 5'(i + 8), tbl[i].exp}) begin
                n_bad++; $display("FAIL ld%0d_data got st=%0b by=%0b stall=%0b rd=%0d v=%h want v=%h", i, store, byp, stall, rd, val, tbl[i].exp); end
            cycle();
            n_cmp++; if (store !== 1'b0) begin n_bad++; $display("FAIL ld%0d_single got st=%0b want 0", i, store); end
        end
    endtask

    task automatic test_load_delay();
        apply_reset();
        x_valid = 1; x_load = 1; x_rd_write = 1; x_rd = 5; x_fun = 3'b010; x_lsb = 0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if ({stall, store} !== 2'b10) begin n_bad++; $display("FAIL delay_c%0d got stall=%0b st=%0b want 1 0", i, stall, store); end
            if (i == 9) begin done = 1; data = 32'hA5A5_5A5A; end
            cycle();
        end
        done = 0;
        n_cmp++; if ({store, stall, rd, val} !== {1'b1, 1'b0, 5'd5, 32'hA5A5_5A5A}) begin
            n_bad++; $display("FAIL delay_store got st=%0b stall=%0b rd=%0d v=%h want 1 0 5 a5a55a5a", store, stall, rd, val); end
        x_load = 0; x_rd = 7; x_val = 32'h0000_0777;
        cycle();
        x_valid = 0;
        n_cmp++; if ({store, byp, rd, val} !== {1'b1, 1'b1, 5'd7, 32'h0000_0777}) begin
            n_bad++; $display("FAIL delay_next got st=%0b by=%0b rd=%0d v=%h want 1 1 7 777", store, byp, rd, val); end
    endtask

    task automatic test_timeout();
        apply_reset();
        x_valid = 1; x_load = 1; x_rd_write = 1; x_rd = 9; x_fun = 3'b010;
        cycle();
        x_valid = 0; x_load = 0;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            n_cmp++; if ({t_stall, t_fault} !== 2'b10) begin n_bad++; $display("FAIL tmo_c%0d got stall=%0b flt=%0b want 1 0", i, t_stall, t_fault); end
        end
        cycle();
        n_cmp++; if ({t_fault, t_stall, t_store} !== 3'b100) begin
            n_bad++; $display("FAIL tmo_fault got flt=%0b stall=%0b st=%0b want 1 0 0", t_fault, t_stall, t_store); end
        done = 1; data = 32'h1234_5678;
        cycle();
        done = 0;
        n_cmp++; if ({t_fault, t_store, t_stall} !== 3'b000) begin
            n_bad++; $display("FAIL tmo_late got flt=%0b st=%0b stall=%0b want 0 0 0", t_fault, t_store, t_stall); end
        // Done on the limit cycle must win over the timeout.
        x_valid = 1; x_load = 1; x_rd = 10;
        cycle();
        x_valid = 0; x_load = 0;
        cycle(); cycle(); cycle();
        done = 1; data = 32'h0BAD_F00D;
        cycle();
        done = 0;
        n_cmp++; if ({t_store, t_fault, t_val} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
            n_bad++; $display("FAIL tmo_race got st=%0b flt=%0b v=%h want 1 0 0badf00d", t_store, t_fault, t_val); end
    endtask

    task automatic test_x0();
        apply_reset();
        x_valid = 1; x_rd_write = 1; x_rd = 0; x_val = 32'hFFFF_FFFF;
        cycle();
        x_valid = 0;
        n_cmp++; if ({store, byp} !== 2'b00) begin n_bad++; $display("FAIL x0_alu got st=%0b by=%0b want 0 0", store, byp); end
        x_valid = 1; x_load = 1;
        cycle();
        x_valid = 0; x_load = 0;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL x0_ldwait got stall=%0b want 1", stall); end
        done = 1; data = 32'h5555_5555;
        cycle();
        done = 0;
        n_cmp++; if ({store, byp, stall} !== 3'b000) begin n_bad++; $display("FAIL x0_load got st=%0b by=%0b stall=%0b want 0 0 0", store, byp, stall); end
    endtask

    task automatic test_reset_midload();
        apply_reset();
        x_valid = 1; x_load = 1; x_rd_write = 1; x_rd = 12; x_fun = 3'b010;
        cycle();
        x_valid = 0; x_load = 0;
        cycle();
        #2 rst = 0;
        #1;
        n_cmp++; if ({stall, store, byp, fault, rd, val, byp_val} !== 72'd0) begin
            n_bad++; $display("FAIL rst_mid got stall=%0b st=%0b by=%0b flt=%0b rd=%0d v=%h want all 0", stall, store, byp, fault, rd, val); end
        rst = 1;
        done = 1; data = 32'h7777_7777;
        cycle();
        done = 0;
        n_cmp++; if ({store, stall} !== 2'b00) begin n_bad++; $display("FAIL rst_discard got st=%0b stall=%0b want 0 0", store, stall); end
    endtask

    task automatic test_random();
        logic [31:0] exp_val;
        bit          exp_st;
        int          dly;
        apply_reset();
        for (int t = 0; t < 60; t++) begin
            x_valid = 1;
            x_load = ($urandom_range(0, 1) == 1);
            x_rd_write = ($urandom_range(0, 4) != 0);
            x_rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            x_val = $urandom;
            x_fun = 3'($urandom_range(0, 7));
            x_lsb = 2'($urandom_range(0, 3));
            done = ($urandom_range(0, 3) == 0);
            data = $urandom;
            exp_st = x_rd_write && (x_rd != 5'd0);
            cycle();
            x_valid = 0; done = 0;
            if (x_load && x_rd_write) begin
                dly = $urandom_range(0, 4);
                exp_val = 32'd0;
                for (int i = 0; i <= dly; i++) begin
                    n_cmp++; if ({stall, store} !== 2'b10) begin n_bad++; $display("FAIL rnd%0d_wait%0d got stall=%0b st=%0b want 1 0", t, i, stall, store); end
                    if (i == dly) begin
                        done = 1; data = $urandom;
                        exp_val = ref_load(int'(x_fun), int'(x_lsb), data);
                    end
                    cycle();
                end
                done = 0;
                n_cmp++; if ({store, byp, stall} !== {exp_st, 1'b0, 1'b0} || (exp_st && (val !== exp_val || rd !== x_rd))) begin
                    n_bad++; $display("FAIL rnd%0d_load got st=%0b by=%0b rd=%0d v=%h want st=%0b rd=%0d v=%h", t, store, byp, rd, val, exp_st, x_rd, exp_val); end
            end else begin
                exp_st = exp_st && !x_load;
                n_cmp++; if ({store, byp, stall} !== {exp_st, exp_st, 1'b0} || (exp_st && (val !== x_val || byp_val !== x_val || rd !== x_rd))) begin
                    n_bad++; $display("FAIL rnd%0d_alu got st=%0b by=%0b rd=%0d v=%h want st=%0b rd=%0d v=%h", t, store, byp, rd, val, exp_st, x_rd, x_val); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_align();
        test_load_delay();
        test_timeout();
        test_x0();
        test_reset_midload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
